// File: rtl/debounce_botoes.sv
// Debounce for four play buttons plus a start button, with a press FSM that
// accepts only single-button plays. Define SINCRONIZADOR_EN to add 2-flop input synchronizers.
module debounce_botoes #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int CONT_W          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes_raw,
    input  logic       jogar_raw,
    output logic [3:0] botoes,
    output logic       jogada_pulso,
    output logic       jogar_pulso,
    output logic       db_multiplo,
    output logic [1:0] db_estado_press
);

    localparam int N = 5;
    localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        ESPERA      = 2'b00,
        PRESSIONADO = 2'b01,
        BLOQUEIO    = 2'b10
    } estado_t;

    logic [N-1:0]      entrada;
    logic [N-1:0]      filtrado;
    logic [CONT_W-1:0] contador [N];
    logic [N-1:0]      nivel;
    logic [3:0]        deb_botoes;
    logic              deb_jogar;

    estado_t    estado;
    estado_t    proximo;
    logic [3:0] valor;
    logic [3:0] valor_prox;
    logic       entrou;
    logic       entrou_prox;
    logic       jogar_ant;
    logic       jogar_sub;

    assign entrada = {jogar_raw, botoes_raw};

`ifdef SINCRONIZADOR_EN
    logic [N-1:0] sinc1;
    logic [N-1:0] sinc2;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sinc1 <= '0;
            sinc2 <= '0;
        end else begin
            sinc1 <= entrada;
            sinc2 <= sinc1;
        end
    end

    assign filtrado = sinc2;
`else
    assign filtrado = entrada;
`endif

    // A level flips only after DEBOUNCE_CICLOS consecutive samples disagreeing with it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                contador[i] <= '0;
            end
            nivel <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (filtrado[i] == nivel[i]) begin
                    contador[i] <= '0;
                end else if (contador[i] == LIMITE) begin
                    contador[i] <= '0;
                    nivel[i]    <= ~nivel[i];
                end else begin
                    contador[i] <= contador[i] + CONT_W'(1);
                end
            end
        end
    end

    assign deb_botoes = nivel[3:0];
    assign deb_jogar  = nivel[4];

    function automatic logic um_quente(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= ESPERA;
            valor  <= 4'b0000;
            entrou <= 1'b0;
        end else begin
            estado <= proximo;
            valor  <= valor_prox;
            entrou <= entrou_prox;
        end
    end

    always_comb begin
        proximo     = estado;
        valor_prox  = valor;
        entrou_prox = 1'b0;
        case (estado)
            ESPERA: begin
                if (um_quente(deb_botoes)) begin
                    proximo     = PRESSIONADO;
                    valor_prox  = deb_botoes;
                    entrou_prox = 1'b1;
                end else if (deb_botoes != 4'b0000) begin
                    proximo = BLOQUEIO;
                end
            end
            PRESSIONADO: begin
                if (deb_botoes == 4'b0000) begin
                    proximo = ESPERA;
                end else if (deb_botoes != valor) begin
                    proximo = BLOQUEIO;
                end
            end
            BLOQUEIO: begin
                if (deb_botoes == 4'b0000) begin
                    proximo = ESPERA;
                end
            end
            default: begin
                proximo = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            jogar_ant <= 1'b0;
            jogar_sub <= 1'b0;
        end else begin
            jogar_ant <= deb_jogar;
            jogar_sub <= deb_jogar & ~jogar_ant;
        end
    end

    // Output stage keeps the start strobe aligned with the play strobe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            botoes          <= 4'b0000;
            jogada_pulso    <= 1'b0;
            jogar_pulso     <= 1'b0;
            db_multiplo     <= 1'b0;
            db_estado_press <= 2'b00;
        end else begin
            botoes          <= (estado == PRESSIONADO) ? valor : 4'b0000;
            jogada_pulso    <= entrou;
            jogar_pulso     <= jogar_sub;
            db_multiplo     <= (estado == BLOQUEIO);
            db_estado_press <= estado;
        end
    end

endmodule

// File: tb/tb_debounce_botoes.sv
// Bench for debounce_botoes: directed scenarios plus random holds, checked
// every cycle against a sliding-window reference model.
module tb_debounce_botoes;

    localparam int D = 4;
`ifdef SINCRONIZADOR_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif
    localparam int LAT = D + 1 + S;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] botoes_raw = 4'b0000;
    logic       jogar_raw = 1'b0;
    logic [3:0] botoes;
    logic       jogada_pulso;
    logic       jogar_pulso;
    logic       db_multiplo;
    logic [1:0] db_estado_press;
    logic [8:0] obs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    debounce_botoes #(.DEBOUNCE_CICLOS(D), .CONT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .botoes_raw(botoes_raw),
        .jogar_raw(jogar_raw),
        .botoes(botoes),
        .jogada_pulso(jogada_pulso),
        .jogar_pulso(jogar_pulso),
        .db_multiplo(db_multiplo),
        .db_estado_press(db_estado_press)
    );

    assign obs = {botoes, jogada_pulso, jogar_pulso, db_multiplo, db_estado_press};

    // Reference model: delay line, window of last D filter samples, press phase
    logic [4:0] atras[$];
    logic [4:0] janela [D];
    logic [4:0] m_deb;
    int         m_fase;
    logic [3:0] m_val;
    logic       m_novo;
    logic       j_d2, j_d3;
    logic [8:0] esperado;

    function automatic bit onehot(input logic [3:0] v);
        int n = 0;
        for (int k = 0; k < 4; k++) if (v[k]) n++;
        return n == 1;
    endfunction

    task automatic model_reset();
        atras.delete();
        for (int k = 0; k < S; k++) atras.push_back(5'b0);
        for (int k = 0; k < D; k++) janela[k] = 5'b0;
        m_deb = 5'b0; m_fase = 0; m_val = 4'b0; m_novo = 1'b0;
        j_d2 = 1'b0; j_d3 = 1'b0; esperado = 9'b0;
    endtask

    task automatic tick();
        logic [4:0] filt;
        logic [3:0] prev;
        bit todos;
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            esperado = {(m_fase == 1) ? m_val : 4'b0, m_novo, j_d2 & ~j_d3,
                        m_fase == 2, 2'(m_fase)};
            j_d3 = j_d2;
            j_d2 = m_deb[4];
            prev = m_deb[3:0];
            m_novo = 1'b0;
            if (m_fase == 0) begin
                if (onehot(prev)) begin m_fase = 1; m_val = prev; m_novo = 1'b1; end
                else if (prev != 4'b0) m_fase = 2;
            end else if (m_fase == 1) begin
                if (prev == 4'b0) m_fase = 0;
                else if (prev != m_val) m_fase = 2;
            end else if (prev == 4'b0) begin
                m_fase = 0;
            end
            atras.push_back({jogar_raw, botoes_raw});
            filt = atras.pop_front();
            for (int k = D - 1; k > 0; k--) janela[k] = janela[k-1];
            janela[0] = filt;
            for (int b = 0; b < 5; b++) begin
                todos = 1;
                for (int k = 0; k < D; k++) if (janela[k][b] == m_deb[b]) todos = 0;
                if (todos) m_deb[b] = ~m_deb[b];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            botoes_raw = 4'($urandom_range(0, 15));
            jogar_raw = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if (obs !== 9'b0) begin
                miscompares++;
                $display("FAIL reset_state cyc=%0d got=%h want=000", i, obs);
            end
        end
        reset = 1'b1; botoes_raw = 4'b0; jogar_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (obs !== esperado) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs, esperado);
            end
        end
    endtask

    task automatic test_single();
        int n = 0, onde = -1;
        botoes_raw = 4'b0100;
        for (int i = 0; i < 35; i++) begin
            if (i == 20) botoes_raw = 4'b0000;
            tick();
            vectors++;
            if (obs !== esperado) begin
                miscompares++;
                $display("FAIL single cyc=%0d got=%h want=%h", i, obs, esperado);
            end
            if (jogada_pulso) begin n++; onde = i; end
            if (i == LAT + 5) begin
                vectors++;
                if (botoes !== 4'b0100) begin
                    miscompares++;
                    $display("FAIL single_held got=%b want=0100", botoes);
                end
            end
        end
        vectors++;
        if (n != 1 || onde != LAT) begin
            miscompares++;
            $display("FAIL single_pulse count=%0d at=%0d want count=1 at=%0d", n, onde, LAT);
        end
    endtask

    task automatic test_glitch();
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            botoes_raw = (i < 30 && ((i >> 1) & 1) == 0) ? 4'b0001 : 4'b0000;
            tick();
            vectors++;
            if (obs !== esperado) begin
                miscompares++;
                $display("FAIL glitch cyc=%0d got=%h want=%h", i, obs, esperado);
            end
            if (jogada_pulso || botoes != 4'b0) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL glitch_quiet active_cycles=%0d want=0", n);
        end
    endtask

    task automatic test_multiple();
        logic [3:0] fases [7];
        logic [3:0] vistos[$];
        int mult = 0;
        fases = '{4'b0001, 4'b0011, 4'b0000, 4'b1000, 4'b0000, 4'b0110, 4'b0000};
        for (int f = 0; f < 7; f++) begin
            botoes_raw = fases[f];
            for (int i = 0; i < 15; i++) begin
                tick();
                vectors++;
                if (obs !== esperado) begin
                    miscompares++;
                    $display("FAIL multiple ph=%0d cyc=%0d got=%h want=%h", f, i, obs, esperado);
                end
                if (jogada_pulso) vistos.push_back(botoes);
                if (db_multiplo) mult++;
            end
        end
        vectors++;
        if (vistos.size() != 2 || vistos[0] !== 4'b0001 || vistos[1] !== 4'b1000 || mult == 0) begin
            miscompares++;
            $display("FAIL multiple_summary pulses=%0d mult_cycles=%0d want pulses=2 (0001,1000) mult>0",
                     vistos.size(), mult);
        end
    endtask

    task automatic test_jogar();
        int nj = 0, np = 0;
        jogar_raw = 1'b1;
        botoes_raw = 4'b0010;
        for (int i = 0; i < 65; i++) begin
            if (i == 20) botoes_raw = 4'b0000;
            if (i == 50) jogar_raw = 1'b0;
            tick();
            vectors++;
            if (obs !== esperado) begin
                miscompares++;
                $display("FAIL jogar cyc=%0d got=%h want=%h", i, obs, esperado);
            end
            if (jogar_pulso) nj++;
            if (jogada_pulso) np++;
        end
        vectors++;
        if (nj != 1 || np != 1) begin
            miscompares++;
            $display("FAIL jogar_counts jogar=%0d jogada=%0d want 1 and 1", nj, np);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, onde = -1;
        botoes_raw = 4'b0010;
        for (int i = 0; i < 15; i++) tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (obs !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_mid_clear got=%h want=000", obs);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (obs !== esperado) begin
                miscompares++;
                $display("FAIL reset_mid cyc=%0d got=%h want=%h", i, obs, esperado);
            end
            if (jogada_pulso) begin n++; onde = i; end
        end
        vectors++;
        if (n != 1 || onde != LAT) begin
            miscompares++;
            $display("FAIL reset_mid_pulse count=%0d at=%0d want count=1 at=%0d", n, onde, LAT);
        end
        botoes_raw = 4'b0000;
        for (int i = 0; i < 15; i++) tick();
    endtask

    task automatic test_random();
        logic [3:0] v = 4'b0;
        int hold;
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 3))
                0: v = 4'b0;
                1: v = 4'(1 << $urandom_range(0, 3));
                2: v = 4'($urandom_range(0, 15));
                default: v = v ^ 4'(1 << $urandom_range(0, 3));
            endcase
            botoes_raw = v;
            jogar_raw = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            hold = $urandom_range(1, 10);
            for (int i = 0; i < hold; i++) begin
                tick();
                reset = 1'b1;
                vectors++;
                if (obs !== esperado) begin
                    miscompares++;
                    $display("FAIL random seg=%0d cyc=%0d got=%h want=%h", seg, i, obs, esperado);
                end
            end
        end
        reset = 1'b1; botoes_raw = 4'b0; jogar_raw = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_glitch();
        test_multiple();
        test_jogar();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
